// File: rtl/calc_pkg.sv
// Shared definitions for the calculator control units.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD3  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell: digits of 5 or more get +3 before the shift.
module bcd_digit_adj
    import calc_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add 3 when the digit would reach 10 or more after doubling; 4-bit wrap.
    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH)
            dout = din + BCD_ADJ_ADD;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to packed BCD converter, one input bit
// per two clocks (adjust, then shift), with init/done handshake.
//
//  state | meaning
//  IDLE  | waiting for init; bcd/overflow hold the last result
//  ADD3  | adjust every scratch digit >= 5 by +3
//  SHIFT | shift {scratch, shreg} left one bit, count down
//  DONE  | result valid; leave once init is seen low
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     scratch;
    logic [BW-1:0]     adj;
    logic              ovf_scr;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (scratch[4*g +: 4]),
                .dout (adj[4*g +: 4])
            );
        end
    endgenerate

    // Handshake status decoded straight from the state register.
    always_comb begin
        busy = (state == ADD3) || (state == SHIFT);
        done = (state == DONE);
    end

    // Conversion FSM, datapath registers and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            scratch  <= '0;
            ovf_scr  <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        shreg   <= bin;
                        scratch <= '0;
                        ovf_scr <= 1'b0;
                        cnt     <= CNT_LOAD;
                        state   <= ADD3;
                    end
                end
                ADD3: begin
                    scratch <= adj;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    {scratch, shreg} <= {scratch[BW-2:0], shreg, 1'b0};
                    ovf_scr          <= ovf_scr | scratch[BW-1];
                    if (cnt != '0)
                        cnt <= cnt - CNT_ONE;
                    // The last bit lands in the result registers on the same edge.
                    if (cnt <= CNT_ONE) begin
                        bcd      <= {scratch[BW-2:0], shreg[WIDTH-1]};
                        overflow <= ovf_scr | scratch[BW-1];
                        state    <= DONE;
                    end else begin
                        state <= ADD3;
                    end
                end
                DONE: begin
                    if (!init)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
